// File: rtl/muldiv_seq.sv
// Multi-cycle HI/LO multiply/divide sequencer: 32-step shift-add multiplier and
// restoring divider that stalls the pipeline and issues a single HI/LO write.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             whi,
  output logic             wlo,
  output logic [WIDTH-1:0] wHiData,
  output logic [WIDTH-1:0] wLoData,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is accepted only in IDLE with flush low; stall holds
  // decode until the DONE cycle, where whi/wlo qualify wHiData/wLoData.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, rsign, rem_sign;
  logic             whi_r, dz_r;
  logic [WIDTH-1:0] acc_hi, acc_lo, b;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic             sgn_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_rem_n, div_q_n;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    sgn_op = !op[0];
    abs_a  = (sgn_op && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    abs_b  = (sgn_op && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;

    // Multiply: acc_hi accumulates, acc_lo holds the multiplier shifting right.
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    div_sh    = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_sh - {1'b0, b};
    div_ok    = !div_diff[WIDTH];
    div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_q_n   = {acc_lo[WIDTH-2:0], div_ok};

    step_hi  = is_div ? div_rem_n : mul_hi_n;
    step_lo  = is_div ? div_q_n   : mul_lo_n;
    prod     = {mul_hi_n, mul_lo_n};
    prod_fix = rsign ? (~prod + 1'b1) : prod;
    if (is_div) begin
      fin_hi = rem_sign ? (~div_rem_n + 1'b1) : div_rem_n;
      fin_lo = rsign    ? (~div_q_n + 1'b1)   : div_q_n;
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      rsign    <= 1'b0;
      rem_sign <= 1'b0;
      whi_r    <= 1'b0;
      dz_r     <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b        <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          whi_r <= 1'b0;
          dz_r  <= 1'b0;
          if (start && !flush) begin
            is_div   <= op[1];
            rsign    <= sgn_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rem_sign <= sgn_op && opa[WIDTH-1];
            acc_hi   <= '0;
            if (op[1] && (opb == '0)) begin
              hi_r  <= opa;
              lo_r  <= '1;
              dz_r  <= 1'b1;
              whi_r <= 1'b1;
              cnt   <= '0;
              state <= DONE;
            end else begin
              acc_lo <= op[1] ? abs_a : abs_b;
              b      <= op[1] ? abs_b : abs_a;
              cnt    <= CW'(WIDTH);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              hi_r  <= fin_hi;
              lo_r  <= fin_lo;
              whi_r <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          whi_r <= 1'b0;
          dz_r  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in DONE suppresses the write that cycle.
  assign whi       = whi_r && !flush;
  assign wlo       = whi_r && !flush;
  assign div_zero  = dz_r && !flush;
  assign wHiData   = hi_r;
  assign wLoData   = lo_r;
  assign stall     = ((state == IDLE) && start && !flush) || (state == CALC);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
